// File: rtl/neuron_product_stage_pkg.sv
// neuron_product_stage_pkg: shared widths, Q4.4 shift default, saturation limits and FSM states.
package neuron_product_stage_pkg;
   localparam int DATA_W = 8;
   localparam int VEC_LEN = 8;
   localparam int IDX_W = $clog2(VEC_LEN);
   localparam int SHIFT_DEF = 4;
   localparam logic signed [DATA_W-1:0] SAT_MAX = 8'h7f;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 8'h80;
   typedef enum logic {COLLECT, HOLD} state_t;
endpackage

// File: rtl/neuron_product_stage_if.sv
// neuron_product_stage_if: weight/bias writes, element stream in, product vector out.
interface neuron_product_stage_if;
   import neuron_product_stage_pkg::*;
   logic w_we;
   logic [IDX_W-1:0] w_addr;
   logic signed [DATA_W-1:0] w_data;
   logic bias_we;
   logic signed [DATA_W-1:0] bias_data;
   logic in_valid;
   logic in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic out_valid;
   logic out_ready;
   logic signed [DATA_W-1:0] prod0, prod1, prod2, prod3, prod4, prod5, prod6, prod7;
   logic signed [DATA_W-1:0] bias_out;
   modport master (
      output w_we, w_addr, w_data, bias_we, bias_data, in_valid, in_data, out_ready,
      input in_ready, out_valid, prod0, prod1, prod2, prod3, prod4, prod5, prod6, prod7, bias_out
   );
   modport slave (
      input w_we, w_addr, w_data, bias_we, bias_data, in_valid, in_data, out_ready,
      output in_ready, out_valid, prod0, prod1, prod2, prod3, prod4, prod5, prod6, prod7, bias_out
   );
endinterface

// File: rtl/neuron_product_stage_q_mul_sat.sv
// q_mul_sat: signed fixed-point multiply, arithmetic right shift, saturate to DATA_W bits.
module q_mul_sat
   import neuron_product_stage_pkg::*;
#(
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] y
);
   logic signed [2*DATA_W-1:0] full, sh;
   always_comb begin
      full = a * b;
      sh = full >>> SHIFT;
      y = (sh > (2*DATA_W)'(SAT_MAX)) ? SAT_MAX :
          (sh < (2*DATA_W)'(SAT_MIN)) ? SAT_MIN : sh[DATA_W-1:0];
   end
endmodule

// File: rtl/neuron_product_stage.sv
// neuron_product_stage: collects 8 streamed activations, multiplies each by its stored weight
// through one shared q_mul_sat, and holds the product vector plus bias snapshot until consumed.
module neuron_product_stage
   import neuron_product_stage_pkg::*;
#(
   parameter int SHIFT = SHIFT_DEF
) (
   input logic clk,
   input logic rst,
   neuron_product_stage_if.slave bus
);
   state_t state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic signed [DATA_W-1:0] w_q [VEC_LEN];
   logic signed [DATA_W-1:0] w_d [VEC_LEN];
   logic signed [DATA_W-1:0] prod_q [VEC_LEN];
   logic signed [DATA_W-1:0] prod_d [VEC_LEN];
   logic signed [DATA_W-1:0] bias_q, bias_d, bias_out_q, bias_out_d, mul_y;
   logic accept;

   // Weight is read from the registered file, so a same-cycle write cannot leak into the product.
   q_mul_sat #(.SHIFT(SHIFT)) u_mul (.a(bus.in_data), .b(w_q[cnt_q]), .y(mul_y));

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      w_d = w_q;
      bias_d = bias_q;
      prod_d = prod_q;
      bias_out_d = bias_out_q;
      accept = (state_q == COLLECT) && bus.in_valid;
      if (bus.w_we) w_d[bus.w_addr] = bus.w_data;
      if (bus.bias_we) bias_d = bus.bias_data;
      if (accept) begin
         prod_d[cnt_q] = mul_y;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(VEC_LEN - 1)) begin
            state_d = HOLD;
            bias_out_d = bias_q;
         end
      end
      if (state_q == HOLD && bus.out_ready) state_d = COLLECT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= COLLECT;
         cnt_q <= '0;
         w_q <= '{default: '0};
         bias_q <= '0;
         prod_q <= '{default: '0};
         bias_out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         w_q <= w_d;
         bias_q <= bias_d;
         prod_q <= prod_d;
         bias_out_q <= bias_out_d;
      end
   end

   assign bus.in_ready = (state_q == COLLECT);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.bias_out = bias_out_q;
   assign bus.prod0 = prod_q[0];
   assign bus.prod1 = prod_q[1];
   assign bus.prod2 = prod_q[2];
   assign bus.prod3 = prod_q[3];
   assign bus.prod4 = prod_q[4];
   assign bus.prod5 = prod_q[5];
   assign bus.prod6 = prod_q[6];
   assign bus.prod7 = prod_q[7];
endmodule

// File: tb/tb_neuron_product_stage.sv
// tb_neuron_product_stage: table vectors plus scoreboarded sequences for latency, backpressure,
// bias snapshot timing, same-cycle weight write and asynchronous reset mid-vector.
module tb_neuron_product_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_pass = 0;
   int n_tot = 0;

   neuron_product_stage_if bus();
   neuron_product_stage #(.SHIFT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0][7:0] p;
      logic [7:0] b;
   } exp_t;
   typedef struct {
      logic signed [7:0] x;
      logic signed [7:0] w;
      logic signed [7:0] e;
   } vec_t;

   exp_t sb[$];
   logic signed [7:0] w_m [8];
   logic signed [7:0] bias_m;

   function automatic logic signed [7:0] mdl(input logic signed [7:0] x, input logic signed [7:0] w);
      int p = int'(x) * int'(w);
      int q = (p < 0) ? -((-p + 15) / 16) : p / 16;
      return 8'((q > 127) ? 127 : (q < -128) ? -128 : q);
   endfunction

   function automatic int get_prod(input int i);
      case (i)
         0: return int'(bus.prod0);
         1: return int'(bus.prod1);
         2: return int'(bus.prod2);
         3: return int'(bus.prod3);
         4: return int'(bus.prod4);
         5: return int'(bus.prod5);
         6: return int'(bus.prod6);
         default: return int'(bus.prod7);
      endcase
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic set_w(input int i, input logic signed [7:0] v);
      @(negedge clk);
      bus.w_we = 1'b1;
      bus.w_addr = 3'(i);
      bus.w_data = v;
      @(negedge clk);
      bus.w_we = 1'b0;
      w_m[i] = v;
   endtask

   task automatic set_bias(input logic signed [7:0] v);
      @(negedge clk);
      bus.bias_we = 1'b1;
      bus.bias_data = v;
      @(negedge clk);
      bus.bias_we = 1'b0;
      bias_m = v;
   endtask

   // ws = element index whose weight is rewritten in its own accept cycle (-1 for none)
   task automatic send_vec(input logic signed [7:0] x [8], input int n, input bit gap,
                           input bit bw, input logic signed [7:0] bd, input int ws);
      exp_t e = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (gap && i == 4) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         if (i == 0) check("in_ready_start", int'(bus.in_ready), 1);
         if (i == 7) check("early_valid", int'(bus.out_valid), 0);
         bus.in_valid = 1'b1;
         bus.in_data = x[i];
         e.p[i] = mdl(x[i], w_m[i]);
         bus.w_we = (i == ws);
         bus.w_addr = 3'(i);
         bus.w_data = ~w_m[i];
         if (i == ws) w_m[i] = ~w_m[i];
         bus.bias_we = bw && (i == 7);
         bus.bias_data = bd;
      end
      if (n == 8) begin
         e.b = bias_m;
         sb.push_back(e);
         if (bw) bias_m = bd;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.w_we = 1'b0;
      bus.bias_we = 1'b0;
      if (n == 8) check("latency", int'(bus.out_valid), 1);
   endtask

   task automatic recv(input string nm);
      exp_t e = '0;
      int t = 0;
      while (!bus.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_valid"}, int'(bus.out_valid), 1);
      check({nm, "_pending"}, sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_prod%0d", nm, i), get_prod(i), int'($signed(e.p[i])));
      check({nm, "_bias"}, int'(bus.bias_out), int'($signed(e.b)));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({nm, "_ret_valid"}, int'(bus.out_valid), 0);
      check({nm, "_ret_ready"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      logic signed [7:0] xv [8];
      vec_t tbl [8];
      bus.w_we = 1'b0;
      bus.w_addr = '0;
      bus.w_data = '0;
      bus.bias_we = 1'b0;
      bus.bias_data = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      w_m = '{default: '0};
      bias_m = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_prod0", get_prod(0), 0);
      check("rst_bias_out", int'(bus.bias_out), 0);

      for (int i = 0; i < 8; i++) begin
         set_w(i, 8'sd32);
         xv[i] = 8'sd16;
      end
      set_bias(8'sd3);
      send_vec(xv, 8, 1'b0, 1'b0, 8'sd0, -1);
      for (int i = 0; i < 8; i++) check($sformatf("all32_prod%0d", i), get_prod(i), 32);
      recv("all32");

      tbl[0] = '{8'sd16, 8'sd32, 8'sd32};
      tbl[1] = '{8'sd127, 8'sd127, 8'sd127};
      tbl[2] = '{8'h80, 8'sd127, 8'h80};
      tbl[3] = '{-8'sd1, 8'sd1, -8'sd1};
      tbl[4] = '{-8'sd1, 8'sd15, -8'sd1};
      tbl[5] = '{8'sd1, 8'sd15, 8'sd0};
      tbl[6] = '{8'h80, 8'sd16, 8'h80};
      tbl[7] = '{8'h80, 8'h80, 8'sd127};
      for (int i = 0; i < 8; i++) begin
         set_w(i, tbl[i].w);
         xv[i] = tbl[i].x;
      end
      send_vec(xv, 8, 1'b1, 1'b0, 8'sd0, 3);
      for (int i = 0; i < 8; i++) check($sformatf("tbl%0d", i), get_prod(i), int'(tbl[i].e));
      recv("tbl");

      for (int i = 0; i < 8; i++) xv[i] = 8'($urandom);
      send_vec(xv, 8, 1'b0, 1'b1, 8'sd5, -1);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 8'sd99;
         @(negedge clk);
         check("bp_in_ready", int'(bus.in_ready), 0);
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_prod7", get_prod(7), int'($signed(sb[0].p[7])));
      end
      bus.in_valid = 1'b0;
      recv("bias_old");
      for (int i = 0; i < 8; i++) xv[i] = 8'($urandom);
      send_vec(xv, 8, 1'b0, 1'b0, 8'sd0, -1);
      recv("bias_new");

      send_vec(xv, 4, 1'b0, 1'b0, 8'sd0, -1);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("arst_prod%0d", i), get_prod(i), 0);
      check("arst_bias_out", int'(bus.bias_out), 0);
      check("arst_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      w_m = '{default: '0};
      bias_m = '0;
      check("post_rst_ready", int'(bus.in_ready), 1);
      for (int i = 0; i < 8; i++) begin
         set_w(i, 8'(i * 12 - 40));
         xv[i] = 8'($urandom);
      end
      set_bias(-8'sd7);
      send_vec(xv, 8, 1'b0, 1'b0, 8'sd0, -1);
      recv("fresh");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
